// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle for the iterative shift sequencer.
// The master issues shift requests and consumes results; the slave is the sequencer.
interface shift_seq_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             ReqValid;
    logic             ReqReady;
    logic [WIDTH-1:0] ReqData;
    logic [SHW-1:0]   ReqAmt;
    logic [1:0]       ReqOp;
    logic             RespValid;
    logic             RespReady;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Busy;

    modport master (
        output ReqValid, ReqData, ReqAmt, ReqOp, RespReady,
        input  ReqReady, RespValid, Result, Zero, Busy
    );

    modport slave (
        input  ReqValid, ReqData, ReqAmt, ReqOp, RespReady,
        output ReqReady, RespValid, Result, Zero, Busy
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Iterative shifter: walks the power-of-two stages one per clock, result on valid/ready.
// Optional rotate-right for op 11 is built only when SHIFT_SEQ_ROTATE_EN is defined.
module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    shift_seq_ctrl_if.slave      bus
);
    localparam int unsigned SHW   = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(SHW + 1);
    localparam int unsigned SA_W  = SHW + 1;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [WIDTH-1:0] work_q,       work_d;
    logic [SHW-1:0]   amt_q,        amt_d;
    logic [1:0]       op_q,         op_d;
    logic             fill_q,       fill_d;
    logic             req_ready_q,  req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic             busy_q,       busy_d;
    logic [WIDTH-1:0] result_q,     result_d;
    logic             zero_q,       zero_d;

    logic [SA_W-1:0]  stage_amt;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] stage_val;
    logic [WIDTH-1:0] stage_next;

    // One stage of the shift: distance 2^cnt, applied only when that amount bit is set.
    always_comb begin
        stage_amt = SA_W'(1) << cnt_q;
        shl_val   = work_q << stage_amt;
        shr_val   = work_q >> stage_amt;
        fill_mask = ~({WIDTH{1'b1}} >> stage_amt);
        stage_val = shr_val;
        case (op_q)
            OP_SLL:  stage_val = shl_val;
            OP_SRL:  stage_val = shr_val;
            OP_SRA:  stage_val = shr_val | (fill_q ? fill_mask : '0);
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROR:  stage_val = shr_val | (work_q << (SA_W'(WIDTH) - stage_amt));
`else
            OP_ROR:  stage_val = shr_val;
`endif
            default: stage_val = shr_val;
        endcase
        stage_next = amt_q[cnt_q] ? stage_val : work_q;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        work_d       = work_q;
        amt_d        = amt_q;
        op_d         = op_q;
        fill_d       = fill_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;
        result_d     = result_q;
        zero_d       = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.ReqValid && req_ready_q) begin
                    work_d      = bus.ReqData;
                    amt_d       = bus.ReqAmt;
                    op_d        = bus.ReqOp;
                    fill_d      = bus.ReqData[WIDTH-1];
                    cnt_d       = '0;
                    state_d     = ST_SHIFT;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_SHIFT: begin
                work_d = stage_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SHW - 1)) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    result_d     = stage_next;
                    zero_d       = (stage_next == '0);
                end
            end
            ST_DONE: begin
                if (bus.RespReady) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    zero_d       = 1'b0;
                    busy_d       = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                zero_d       = 1'b0;
                busy_d       = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            work_q       <= '0;
            amt_q        <= '0;
            op_q         <= '0;
            fill_q       <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            work_q       <= work_d;
            amt_q        <= amt_d;
            op_q         <= op_d;
            fill_q       <= fill_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
        end
    end

    assign bus.ReqReady  = req_ready_q;
    assign bus.RespValid = resp_valid_q;
    assign bus.Busy      = busy_q;
    assign bus.Result    = result_q;
    assign bus.Zero      = zero_q;
endmodule
